// File: rtl/riscv_regfile_switch_ctrl.sv
// Handover controller for the dual register file: stalls the core, copies r1..rN from the
// active file into the inactive one, then flips reg_mux_o. Optional read-back check: RF_SWITCH_VERIFY_EN.
module riscv_regfile_switch_ctrl #(
   parameter int   ADDR_WIDTH = 5,
   parameter int   DATA_WIDTH = 32,
   parameter logic RESET_SEL  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sel_req_i,
   input  logic                  core_idle_i,
   output logic                  reg_mux_o,
   output logic                  stall_o,
   output logic                  en_mpscm_o,
   output logic                  en_orig_o,
   output logic [ADDR_WIDTH-1:0] cp_raddr_o,
   input  logic [DATA_WIDTH-1:0] cp_rdata_i,
   output logic [ADDR_WIDTH-1:0] cp_waddr_o,
   output logic [DATA_WIDTH-1:0] cp_wdata_o,
   output logic                  cp_we_o,
   output logic                  done_o,
   input  logic [DATA_WIDTH-1:0] cp_vrdata_i,
   output logic                  err_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);

`ifdef RF_SWITCH_VERIFY_EN
   typedef enum logic [2:0] {S_IDLE, S_WAIT_IDLE, S_COPY, S_FLUSH, S_VERIFY, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_WAIT_IDLE, S_COPY, S_FLUSH, S_DONE} state_t;
`endif

   state_t                state_q, state_d;
   logic                  reg_mux_q, reg_mux_d;
   logic                  target_q, target_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic                  done_q, done_d;
`ifdef RF_SWITCH_VERIFY_EN
   logic                  mism_q, mism_d;
   logic                  err_q, err_d;
`endif

   always_comb begin
      state_d   = state_q;
      reg_mux_d = reg_mux_q;
      target_d  = target_q;
      raddr_d   = raddr_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      we_d      = 1'b0;
      done_d    = 1'b0;
`ifdef RF_SWITCH_VERIFY_EN
      mism_d    = 1'b0;
      err_d     = err_q | mism_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (sel_req_i != reg_mux_q) begin
               target_d = sel_req_i;
               state_d  = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (core_idle_i) begin
               raddr_d = FIRST_ADDR;
               state_d = S_COPY;
            end
         end
         S_COPY: begin
            // One-stage pipeline: the write of register k appears the cycle after it is read.
            waddr_d = raddr_q;
            wdata_d = cp_rdata_i;
            we_d    = 1'b1;
            if (raddr_q == LAST_ADDR) begin
               raddr_d = '0;
               state_d = S_FLUSH;
            end else begin
               raddr_d = raddr_q + FIRST_ADDR;
            end
         end
         S_FLUSH: begin
`ifdef RF_SWITCH_VERIFY_EN
            raddr_d = FIRST_ADDR;
            state_d = S_VERIFY;
`else
            done_d  = 1'b1;
            state_d = S_DONE;
`endif
         end
`ifdef RF_SWITCH_VERIFY_EN
         S_VERIFY: begin
            // Address 0 marks the drain cycle that folds the last compare into err.
            mism_d = (raddr_q != '0) && (cp_rdata_i != cp_vrdata_i);
            if (raddr_q == '0) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (raddr_q == LAST_ADDR) begin
               raddr_d = '0;
            end else begin
               raddr_d = raddr_q + FIRST_ADDR;
            end
         end
`endif
         S_DONE: begin
            reg_mux_d = target_q;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         reg_mux_q <= RESET_SEL;
         target_q  <= RESET_SEL;
         raddr_q   <= '0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         done_q    <= 1'b0;
`ifdef RF_SWITCH_VERIFY_EN
         mism_q    <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         reg_mux_q <= reg_mux_d;
         target_q  <= target_d;
         raddr_q   <= raddr_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         done_q    <= done_d;
`ifdef RF_SWITCH_VERIFY_EN
         mism_q    <= mism_d;
         err_q     <= err_d;
`endif
      end
   end

   assign reg_mux_o  = reg_mux_q;
   assign stall_o    = (state_q != S_IDLE);
   assign en_mpscm_o = stall_o | ~reg_mux_q;
   assign en_orig_o  = stall_o | reg_mux_q;
   assign cp_raddr_o = raddr_q;
   assign cp_waddr_o = waddr_q;
   assign cp_wdata_o = wdata_q;
   assign cp_we_o    = we_q;
   assign done_o     = done_q;

`ifdef RF_SWITCH_VERIFY_EN
   assign err_o = err_q;
`else
   logic unused_vrdata;
   assign unused_vrdata = ^cp_vrdata_i;
   assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_regfile_switch_ctrl.sv
// Directed bench for riscv_regfile_switch_ctrl: copy order, stall window, idle wait,
// mid-copy request change, async reset mid-copy and (with RF_SWITCH_VERIFY_EN) verify error.
module tb_riscv_regfile_switch_ctrl;
   localparam int AW = 5;
   localparam int DW = 32;
`ifdef RF_SWITCH_VERIFY_EN
   localparam int VERIFY_CYC = 32;
`else
   localparam int VERIFY_CYC = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sel_req_i = 1'b1;
   logic          core_idle_i = 1'b1;
   logic          reg_mux_o, stall_o, en_mpscm_o, en_orig_o;
   logic [AW-1:0] cp_raddr_o, cp_waddr_o;
   logic [DW-1:0] cp_rdata_i, cp_wdata_o, cp_vrdata_i;
   logic          cp_we_o, done_o, err_o;

   logic [DW-1:0] src_mem [32];
   logic          corrupt = 1'b0;

   int tests_run = 0;
   int fails = 0;

   int mon_en = 0;
   int stall_cnt, done_cnt, zero_wr;
   logic [AW+DW-1:0] wr_q[$];
   logic [AW+DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   assign cp_rdata_i  = src_mem[cp_raddr_o];
   assign cp_vrdata_i = (corrupt && cp_raddr_o == 5'd7) ? ~src_mem[cp_raddr_o] : src_mem[cp_raddr_o];

   riscv_regfile_switch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_SEL(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .sel_req_i(sel_req_i), .core_idle_i(core_idle_i),
      .reg_mux_o(reg_mux_o), .stall_o(stall_o), .en_mpscm_o(en_mpscm_o), .en_orig_o(en_orig_o),
      .cp_raddr_o(cp_raddr_o), .cp_rdata_i(cp_rdata_i), .cp_waddr_o(cp_waddr_o),
      .cp_wdata_o(cp_wdata_o), .cp_we_o(cp_we_o), .done_o(done_o),
      .cp_vrdata_i(cp_vrdata_i), .err_o(err_o)
   );

   always @(negedge clk) begin
      if (mon_en != 0) begin
         if (stall_o) stall_cnt++;
         if (done_o) done_cnt++;
         if (cp_we_o) begin
            if (cp_waddr_o == '0) zero_wr++;
            wr_q.push_back({cp_waddr_o, cp_wdata_o});
         end
      end
   end

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (done_o) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      tests_run++;
      if ({reg_mux_o, stall_o, en_orig_o, en_mpscm_o, cp_we_o, done_o, err_o} !== 7'b1010000) begin
         fails++;
         $display("FAIL reset_flags got mux/stall/orig/mpscm/we/done/err=%b want 1010000",
                  {reg_mux_o, stall_o, en_orig_o, en_mpscm_o, cp_we_o, done_o, err_o});
      end
      tests_run++;
      if ({cp_raddr_o, cp_waddr_o, cp_wdata_o} !== '0) begin
         fails++;
         $display("FAIL reset_addr got raddr=%0d waddr=%0d wdata=%h want 0", cp_raddr_o, cp_waddr_o, cp_wdata_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_full_copy;
      bit ok;
      logic [AW+DW-1:0] a, e;
      int bad;
      exp_q.delete();
      wr_q.delete();
      for (int n = 1; n < 32; n++) exp_q.push_back({5'(n), 32'h1000 + 32'(n)});
      stall_cnt = 0; done_cnt = 0; zero_wr = 0;
      @(negedge clk);
      core_idle_i = 1'b1;
      sel_req_i   = 1'b0;
      mon_en      = 1;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if ({en_mpscm_o, en_orig_o} !== 2'b11) begin
         fails++;
         $display("FAIL copy_enables got mpscm/orig=%b want 11", {en_mpscm_o, en_orig_o});
      end
      wait_done(200, ok);
      tests_run++;
      if (!ok) begin
         fails++;
         $display("FAIL copy_done_timeout got no done_o want pulse within 200 cycles");
      end
      repeat (3) @(negedge clk);
      mon_en = 0;
      tests_run++;
      if (stall_cnt !== 34 + VERIFY_CYC) begin
         fails++;
         $display("FAIL copy_stall_cycles got %0d want %0d", stall_cnt, 34 + VERIFY_CYC);
      end
      tests_run++;
      if (wr_q.size() !== 31 || zero_wr !== 0) begin
         fails++;
         $display("FAIL copy_write_count got %0d writes (%0d to r0) want 31 (0 to r0)", wr_q.size(), zero_wr);
      end
      bad = 0;
      while (exp_q.size() > 0 && wr_q.size() > 0) begin
         e = exp_q.pop_front();
         a = wr_q.pop_front();
         if (a !== e) begin
            if (bad == 0) $display("FAIL copy_write_data got addr=%0d data=%h want addr=%0d data=%h",
                                   a[AW+DW-1:DW], a[DW-1:0], e[AW+DW-1:DW], e[DW-1:0]);
            bad++;
         end
      end
      tests_run++;
      if (bad != 0) fails++;
      tests_run++;
      if (done_cnt !== 1 || reg_mux_o !== 1'b0 || err_o !== 1'b0) begin
         fails++;
         $display("FAIL copy_result got done_cnt=%0d mux=%b err=%b want 1 0 0", done_cnt, reg_mux_o, err_o);
      end
      tests_run++;
      if ({stall_o, en_mpscm_o, en_orig_o} !== 3'b010) begin
         fails++;
         $display("FAIL copy_idle_enables got stall/mpscm/orig=%b want 010", {stall_o, en_mpscm_o, en_orig_o});
      end
   endtask

   task automatic test_wait_idle;
      bit ok;
      int bad = 0;
      @(negedge clk);
      core_idle_i = 1'b0;
      sel_req_i   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (stall_o !== 1'b1 || cp_we_o !== 1'b0) begin
            if (bad == 0) $display("FAIL wait_hold cycle %0d got stall=%b we=%b want 1 0", i, stall_o, cp_we_o);
            bad++;
         end
      end
      tests_run++;
      if (bad != 0) fails++;
      core_idle_i = 1'b1;
      @(negedge clk);
      tests_run++;
      if (cp_raddr_o !== 5'd1 || cp_we_o !== 1'b0) begin
         fails++;
         $display("FAIL wait_copy_start got raddr=%0d we=%b want 1 0", cp_raddr_o, cp_we_o);
      end
      @(negedge clk);
      tests_run++;
      if (cp_we_o !== 1'b1 || cp_waddr_o !== 5'd1 || cp_wdata_o !== 32'h1001) begin
         fails++;
         $display("FAIL wait_first_write got we=%b addr=%0d data=%h want 1 1 00001001", cp_we_o, cp_waddr_o, cp_wdata_o);
      end
      wait_done(200, ok);
      @(negedge clk);
      tests_run++;
      if (!ok || reg_mux_o !== 1'b1) begin
         fails++;
         $display("FAIL wait_result got done_seen=%b mux=%b want 1 1", ok, reg_mux_o);
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      @(negedge clk);
      core_idle_i = 1'b1;
      sel_req_i   = 1'b0;
      repeat (10) @(negedge clk);
      sel_req_i = 1'b1;
      wait_done(200, ok);
      tests_run++;
      if (!ok || reg_mux_o !== 1'b1) begin
         fails++;
         $display("FAIL b2b_first_done got done_seen=%b mux=%b want 1 1", ok, reg_mux_o);
      end
      @(negedge clk);
      tests_run++;
      if (reg_mux_o !== 1'b0 || stall_o !== 1'b0) begin
         fails++;
         $display("FAIL b2b_flip got mux=%b stall=%b want 0 0", reg_mux_o, stall_o);
      end
      @(negedge clk);
      tests_run++;
      if (stall_o !== 1'b1) begin
         fails++;
         $display("FAIL b2b_restart got stall=%b want 1", stall_o);
      end
      wait_done(200, ok);
      @(negedge clk);
      tests_run++;
      if (!ok || reg_mux_o !== 1'b1) begin
         fails++;
         $display("FAIL b2b_second got done_seen=%b mux=%b want 1 1", ok, reg_mux_o);
      end
   endtask

   task automatic test_reset_mid_copy;
      bit hit = 1'b0;
      @(negedge clk);
      core_idle_i = 1'b1;
      sel_req_i   = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (stall_o && cp_raddr_o == 5'd12) hit = 1'b1;
      end
      tests_run++;
      if (!hit) begin
         fails++;
         $display("FAIL rst_mid_reach got no COPY at address 12 want reached");
      end
      #1 rst_n = 1'b0;
      sel_req_i = 1'b1;
      #1;
      tests_run++;
      if ({reg_mux_o, stall_o, cp_we_o, done_o} !== 4'b1000 || cp_raddr_o !== '0) begin
         fails++;
         $display("FAIL rst_mid_state got mux/stall/we/done=%b raddr=%0d want 1000 0",
                  {reg_mux_o, stall_o, cp_we_o, done_o}, cp_raddr_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (reg_mux_o !== 1'b1 || stall_o !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_after got mux=%b stall=%b want 1 0", reg_mux_o, stall_o);
      end
   endtask

`ifdef RF_SWITCH_VERIFY_EN
   task automatic test_verify_err;
      bit ok;
      @(negedge clk);
      corrupt     = 1'b1;
      core_idle_i = 1'b1;
      sel_req_i   = 1'b0;
      wait_done(200, ok);
      tests_run++;
      if (!ok || err_o !== 1'b1) begin
         fails++;
         $display("FAIL verify_err got done_seen=%b err=%b want 1 1", ok, err_o);
      end
      corrupt = 1'b0;
      @(negedge clk);
      tests_run++;
      if (reg_mux_o !== 1'b0) begin
         fails++;
         $display("FAIL verify_flip got mux=%b want 0", reg_mux_o);
      end
      repeat (5) @(negedge clk);
      tests_run++;
      if (err_o !== 1'b1) begin
         fails++;
         $display("FAIL verify_sticky got err=%b want 1", err_o);
      end
   endtask
`endif

   initial begin
      for (int n = 0; n < 32; n++) src_mem[n] = 32'h1000 + 32'(n);
      test_reset();
      test_full_copy();
      test_wait_idle();
      test_back_to_back();
      test_reset_mid_copy();
`ifdef RF_SWITCH_VERIFY_EN
      test_verify_err();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish want finish before 200000");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/riscv_regfile_switch_ctrl.md
Name: riscv_regfile_switch_ctrl

Overview:
- Run-time handover controller for the dual register-file arrangement: MPSCM (select 0) and original RTL regfile (select 1).
- On a request to change the active regfile, it stalls the core and waits for the core to go idle. It then copies every writable register from the active (source) file to the inactive (destination) file, and only then flips the select that drives the regfile mux/demux.
- Acts as the reader of the source file and the writer of the destination file, so architectural state survives a switch.

Parameters:
- ADDR_WIDTH, 5, regfile address width; registers copied are 1 .. 2**ADDR_WIDTH-1.
- DATA_WIDTH, 32, register data width.
- RESET_SEL, 1, value of reg_mux_o after reset (1 = original regfile).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- sel_req_i  in  1  requested regfile select
- core_idle_i  in  1  no instruction in flight, no pending regfile write
- reg_mux_o  out  1  active regfile select, drives the mux/demux select
- stall_o  out  1  core stall request
- en_mpscm_o  out  1  MPSCM clock-gate enable
- en_orig_o  out  1  original-regfile clock-gate enable
- cp_raddr_o  out  ADDR_WIDTH  copy read address into the source file
- cp_rdata_i  in  DATA_WIDTH  source read data, combinational w.r.t. cp_raddr_o
- cp_waddr_o  out  ADDR_WIDTH  copy write address into the destination file
- cp_wdata_o  out  DATA_WIDTH  copy write data
- cp_we_o  out  1  copy write enable to the destination file
- done_o  out  1  one-cycle pulse when the switch completes
- cp_vrdata_i  in  DATA_WIDTH  destination read data at cp_raddr_o (only with RF_SWITCH_VERIFY_EN)
- err_o  out  1  sticky verify mismatch (only with RF_SWITCH_VERIFY_EN)

Behaviour:
- Reset values:
  - reg_mux_o = RESET_SEL; state = IDLE.
  - stall_o, cp_we_o, done_o, err_o = 0.
  - cp_raddr_o, cp_waddr_o, cp_wdata_o = 0.
- Clock-gate enables:
  - In IDLE, en_mpscm_o = ~reg_mux_o and en_orig_o = reg_mux_o.
  - In every other state both enables are 1.
- stall_o = 1 whenever state != IDLE, decoded from registered state.
- FSM states: IDLE, WAIT_IDLE, COPY, FLUSH, (VERIFY), DONE.
  - IDLE: if sel_req_i != reg_mux_o, latch target = sel_req_i and go to WAIT_IDLE.
  - WAIT_IDLE: hold until core_idle_i = 1, then go to COPY with cp_raddr_o = 1.
  - COPY: each cycle, capture cp_rdata_i and the current address into a one-stage pipeline register, then increment cp_raddr_o.
    - The pipeline drives cp_waddr_o/cp_wdata_o, with cp_we_o = 1 from the second COPY cycle onward.
    - When cp_raddr_o = 2**ADDR_WIDTH-1, go to FLUSH.
  - FLUSH: write the last pipelined register (cp_we_o = 1), then go to DONE (or to VERIFY when the feature is enabled).
  - DONE: reg_mux_o <= target, done_o = 1 for this cycle, go to IDLE. stall_o drops the cycle after DONE.
- Address 0 is never read or written by the copy; cp_we_o never asserts with cp_waddr_o = 0.
- Latency: from core_idle_i seen in WAIT_IDLE, 2**ADDR_WIDTH-1 COPY cycles + 1 FLUSH + 1 DONE. For ADDR_WIDTH=5 that is 33 cycles.
- Changes on sel_req_i after the latch are ignored until IDLE. If sel_req_i still differs from the new reg_mux_o in IDLE, a new switch starts.
- core_idle_i dropping during COPY/FLUSH is ignored; stall_o guarantees the source is frozen.
- An asynchronous reset mid-switch returns to the reset state: reg_mux_o = RESET_SEL and the partial copy is discarded.
- cp_we_o is 0 in IDLE, WAIT_IDLE, VERIFY and DONE.

Optional Feature:
- Macro: RF_SWITCH_VERIFY_EN.
- Enabled: after FLUSH the FSM enters VERIFY.
  - cp_raddr_o sweeps 1 .. 2**ADDR_WIDTH-1 again; cp_rdata_i and cp_vrdata_i are compared and the result registered.
  - Any mismatch sets err_o, which stays set until reset. This adds 2**ADDR_WIDTH cycles before DONE.
  - The switch still completes even when err_o is set.
- Disabled: there is no VERIFY state, err_o is tied to 0 and cp_vrdata_i is unused.

Test Plan:
- Reset with RESET_SEL=1 -> reg_mux_o=1, stall_o=0, en_orig_o=1, en_mpscm_o=0, cp_we_o=0.
- Preload src r1..r31 = 0x1000+n, sel_req_i=0, core_idle_i=1 -> stall high 34 cycles, 31 writes with waddr n / wdata 0x1000+n in order, no write to addr 0, done_o pulse, reg_mux_o=0.
- sel_req_i=0 with core_idle_i=0 for 10 cycles -> stay in WAIT_IDLE, stall_o=1, cp_we_o=0; copy starts the cycle after core_idle_i rises.
- Toggle sel_req_i back to 1 mid-COPY -> current switch completes to 0, then a second switch to 1 starts from IDLE.
- Assert rst_n=0 at COPY address 12 -> immediate reg_mux_o=1, stall_o=0, cp_we_o=0.
- RF_SWITCH_VERIFY_EN with cp_vrdata_i forced wrong at r7 -> err_o=1 and sticky, done_o still pulses, reg_mux_o flips.
